grid_controller: RTL and testbench

//  Sequential writer of the 3x3 tic-tac-toe board: accepts player move requests, validates them,

---
 rtl/tictactoe_pkg.sv | 37 +++
 rtl/grid_controller_if.sv | 36 +++
 rtl/cell_decode.sv | 28 ++
 rtl/grid_controller.sv | 146 ++++++++++++++
 tb/tb_grid_controller.sv | 222 ++++++++++++++++++++++
 5 files changed

// File: rtl/tictactoe_pkg.sv
// rtl/tictactoe_pkg.sv - shared cell, outcome, index and state codes for the tic-tac-toe board
package tictactoe_pkg;

  localparam logic [1:0] CELL_EMPTY = 2'b00;
  localparam logic [1:0] CELL_P1    = 2'b01;
  localparam logic [1:0] CELL_P2    = 2'b10;

  localparam logic [1:0] OUT_IN_PROGRESS = 2'd0;
  localparam logic [1:0] OUT_P1_WIN      = 2'd1;
  localparam logic [1:0] OUT_P1_LOSE     = 2'd2;
  localparam logic [1:0] OUT_TIE         = 2'd3;

  localparam logic [3:0] IDX_A1 = 4'd0;
  localparam logic [3:0] IDX_A2 = 4'd1;
  localparam logic [3:0] IDX_A3 = 4'd2;
  localparam logic [3:0] IDX_B1 = 4'd3;
  localparam logic [3:0] IDX_B2 = 4'd4;
  localparam logic [3:0] IDX_B3 = 4'd5;
  localparam logic [3:0] IDX_C1 = 4'd6;
  localparam logic [3:0] IDX_C2 = 4'd7;
  localparam logic [3:0] IDX_C3 = 4'd8;

  localparam logic [3:0] MAX_MOVES = 4'd9;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_WAIT_MOVE = 2'd1,
    ST_CHECK     = 2'd2,
    ST_DONE      = 2'd3
  } state_t;

  // Any non-P1 mark maps to P1 so an illegal code can never persist as a turn.
  function automatic logic [1:0] other_player(input logic [1:0] p);
    return (p == CELL_P1) ? CELL_P2 : CELL_P1;
  endfunction

endpackage

// File: rtl/grid_controller_if.sv
// rtl/grid_controller_if.sv - move request, checker outcome and board state bundle
interface grid_controller_if;

  logic       start;
  logic [3:0] cell_sel;
  logic       place;
  logic [1:0] outcome;

  logic [1:0] grid_A1;
  logic [1:0] grid_A2;
  logic [1:0] grid_A3;
  logic [1:0] grid_B1;
  logic [1:0] grid_B2;
  logic [1:0] grid_B3;
  logic [1:0] grid_C1;
  logic [1:0] grid_C2;
  logic [1:0] grid_C3;
  logic [1:0] turn;
  logic [3:0] move_count;
  logic       move_ok;
  logic       move_err;
  logic       game_over;

  modport master (
    output start, cell_sel, place, outcome,
    input  grid_A1, grid_A2, grid_A3, grid_B1, grid_B2, grid_B3, grid_C1, grid_C2, grid_C3,
    input  turn, move_count, move_ok, move_err, game_over
  );

  modport slave (
    input  start, cell_sel, place, outcome,
    output grid_A1, grid_A2, grid_A3, grid_B1, grid_B2, grid_B3, grid_C1, grid_C2, grid_C3,
    output turn, move_count, move_ok, move_err, game_over
  );

endinterface

// File: rtl/cell_decode.sv
// rtl/cell_decode.sv - cell index to one-hot write enable plus range flag
module cell_decode
  import tictactoe_pkg::*;
(
  input  logic [3:0] idx,
  output logic [8:0] we,
  output logic       valid
);

  // Indices 9..15 decode to no enable and a cleared valid flag.
  always_comb begin
    we    = '0;
    valid = 1'b1;
    case (idx)
      IDX_A1:  we[0] = 1'b1;
      IDX_A2:  we[1] = 1'b1;
      IDX_A3:  we[2] = 1'b1;
      IDX_B1:  we[3] = 1'b1;
      IDX_B2:  we[4] = 1'b1;
      IDX_B3:  we[5] = 1'b1;
      IDX_C1:  we[6] = 1'b1;
      IDX_C2:  we[7] = 1'b1;
      IDX_C3:  we[8] = 1'b1;
      default: valid = 1'b0;
    endcase
  end

endmodule

// File: rtl/grid_controller.sv
// rtl/grid_controller.sv - validates moves, writes the 3x3 board, alternates turns, freezes on game end
module grid_controller
  import tictactoe_pkg::*;
#(
  parameter logic [1:0] FIRST_PLAYER = 2'b01,
  parameter logic       ALT_START    = 1'b0
) (
  input  logic              clk,
  input  logic              rst,
  grid_controller_if.slave  bus
);

  state_t     state_q, state_d;
  logic [1:0] board_q [9];
  logic [1:0] board_d [9];
  logic [1:0] turn_q, turn_d;
  logic [1:0] first_q, first_d;
  logic       started_q, started_d;
  logic [3:0] count_q, count_d;
  logic       move_ok_q, move_ok_d;
  logic       move_err_q, move_err_d;
  logic       game_over_q, game_over_d;

  logic [8:0] sel_we;
  logic       sel_valid;
  logic [8:0] occupied;
  logic       target_busy;
  logic [1:0] new_first;

  cell_decode u_cell_decode (
    .idx   (bus.cell_sel),
    .we    (sel_we),
    .valid (sel_valid)
  );

  // Occupancy of the selected cell and the first mover a start would install.
  always_comb begin
    for (int i = 0; i < 9; i++) begin
      occupied[i] = (board_q[i] != CELL_EMPTY);
    end
    target_busy = |(sel_we & occupied);
    new_first   = (ALT_START && started_q) ? other_player(first_q) : FIRST_PLAYER;
  end

  // Next-state: start has priority; otherwise FSM handles place and the one-cycle check.
  always_comb begin
    state_d     = state_q;
    for (int i = 0; i < 9; i++) begin
      board_d[i] = board_q[i];
    end
    turn_d      = turn_q;
    first_d     = first_q;
    started_d   = started_q;
    count_d     = count_q;
    move_ok_d   = 1'b0;
    move_err_d  = 1'b0;
    game_over_d = game_over_q;

    if (bus.start) begin
      for (int i = 0; i < 9; i++) begin
        board_d[i] = CELL_EMPTY;
      end
      count_d     = '0;
      game_over_d = 1'b0;
      turn_d      = new_first;
      first_d     = new_first;
      started_d   = 1'b1;
      state_d     = ST_WAIT_MOVE;
    end else begin
      case (state_q)
        ST_WAIT_MOVE: begin
          if (bus.place) begin
            if (sel_valid && !target_busy) begin
              for (int i = 0; i < 9; i++) begin
                if (sel_we[i]) board_d[i] = turn_q;
              end
              count_d   = (count_q == MAX_MOVES) ? count_q : count_q + 4'd1;
              move_ok_d = 1'b1;
              state_d   = ST_CHECK;
            end else begin
              move_err_d = 1'b1;
            end
          end
        end
        ST_CHECK: begin
          move_err_d = bus.place;
          if (bus.outcome != OUT_IN_PROGRESS || count_q == MAX_MOVES) begin
            game_over_d = 1'b1;
            state_d     = ST_DONE;
          end else begin
            turn_d  = other_player(turn_q);
            state_d = ST_WAIT_MOVE;
          end
        end
        default: begin
          move_err_d = bus.place;
        end
      endcase
    end
  end

  // State register with synchronous active-high reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      for (int i = 0; i < 9; i++) begin
        board_q[i] <= CELL_EMPTY;
      end
      turn_q      <= FIRST_PLAYER;
      first_q     <= FIRST_PLAYER;
      started_q   <= 1'b0;
      count_q     <= '0;
      move_ok_q   <= 1'b0;
      move_err_q  <= 1'b0;
      game_over_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      for (int i = 0; i < 9; i++) begin
        board_q[i] <= board_d[i];
      end
      turn_q      <= turn_d;
      first_q     <= first_d;
      started_q   <= started_d;
      count_q     <= count_d;
      move_ok_q   <= move_ok_d;
      move_err_q  <= move_err_d;
      game_over_q <= game_over_d;
    end
  end

  assign bus.grid_A1    = board_q[0];
  assign bus.grid_A2    = board_q[1];
  assign bus.grid_A3    = board_q[2];
  assign bus.grid_B1    = board_q[3];
  assign bus.grid_B2    = board_q[4];
  assign bus.grid_B3    = board_q[5];
  assign bus.grid_C1    = board_q[6];
  assign bus.grid_C2    = board_q[7];
  assign bus.grid_C3    = board_q[8];
  assign bus.turn       = turn_q;
  assign bus.move_count = count_q;
  assign bus.move_ok    = move_ok_q;
  assign bus.move_err   = move_err_q;
  assign bus.game_over  = game_over_q;

endmodule

// File: tb/tb_grid_controller.sv
// tb/tb_grid_controller.sv - game-level model plus directed moves for grid_controller
module tb_grid_controller;

  logic clk = 1'b0;
  logic rst;

  grid_controller_if bus ();

  grid_controller #(
    .FIRST_PLAYER (2'b01),
    .ALT_START    (1'b0)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  int out_mode;

  int lines [8][3] = '{'{0,1,2}, '{3,4,5}, '{6,7,8}, '{0,3,6},
                       '{1,4,7}, '{2,5,8}, '{0,4,8}, '{2,4,6}};

  logic [17:0] dut_grid;
  assign dut_grid = {bus.grid_C3, bus.grid_C2, bus.grid_C1,
                     bus.grid_B3, bus.grid_B2, bus.grid_B1,
                     bus.grid_A3, bus.grid_A2, bus.grid_A1};

  // Environment checker: P1 line -> 1, P2 line -> 2, full board -> 3, else 0.
  function automatic logic [1:0] judge(input logic [17:0] g);
    int full;
    full = 1;
    for (int l = 0; l < 8; l++) begin
      logic [1:0] a, b, c;
      a = g[2*lines[l][0] +: 2];
      b = g[2*lines[l][1] +: 2];
      c = g[2*lines[l][2] +: 2];
      if (a != 2'b00 && a == b && b == c) return a;
    end
    for (int k = 0; k < 9; k++) if (g[2*k +: 2] == 2'b00) full = 0;
    return (full != 0) ? 2'd3 : 2'd0;
  endfunction

  always_comb bus.outcome = (out_mode != 0) ? judge(dut_grid) : 2'b00;

  // Game-level model: board of marks, whose turn, a pending-judgement flag.
  int m_board [9];
  int m_turn, m_count;
  bit m_ok, m_err, m_over, m_running, m_pending;

  always @(posedge clk) begin
    if (rst) begin
      for (int k = 0; k < 9; k++) m_board[k] = 0;
      m_turn = 1; m_count = 0;
      m_ok = 0; m_err = 0; m_over = 0; m_running = 0; m_pending = 0;
    end else begin
      m_ok = 0; m_err = 0;
      if (bus.start) begin
        for (int k = 0; k < 9; k++) m_board[k] = 0;
        m_turn = 1; m_count = 0; m_over = 0; m_running = 1; m_pending = 0;
      end else if (m_pending) begin
        m_pending = 0;
        if (bus.place) m_err = 1;
        if (bus.outcome != 0 || m_count == 9) begin
          m_over = 1; m_running = 0;
        end else begin
          m_turn = 3 - m_turn;
        end
      end else if (bus.place) begin
        if (m_running && bus.cell_sel <= 8 && m_board[bus.cell_sel] == 0) begin
          m_board[bus.cell_sel] = m_turn;
          if (m_count < 9) m_count = m_count + 1;
          m_ok = 1; m_pending = 1;
        end else begin
          m_err = 1;
        end
      end
    end
  end

  function automatic logic [26:0] model_vec();
    logic [17:0] g;
    for (int k = 0; k < 9; k++) g[2*k +: 2] = m_board[k][1:0];
    return {g, m_turn[1:0], m_count[3:0], m_ok, m_err, m_over};
  endfunction

  logic [26:0] dut_vec;
  assign dut_vec = {dut_grid, bus.turn, bus.move_count, bus.move_ok, bus.move_err, bus.game_over};

  task automatic tick();
    @(negedge clk);
    total++;
    if (dut_vec !== model_vec()) begin
      bad++;
      $display("FAIL cycle t=%0t dut=%h model=%h", $time, dut_vec, model_vec());
    end
  endtask

  task automatic lit(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s got=%0h expected=%0h", name, act, exp);
    end
  endtask

  task automatic place_at(input int sel);
    bus.place    = 1'b1;
    bus.cell_sel = sel[3:0];
    tick();
    bus.place    = 1'b0;
  endtask

  task automatic pulse_start();
    bus.start = 1'b1;
    tick();
    bus.start = 1'b0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    rst = 1'b1; bus.start = 1'b0; bus.place = 1'b0; bus.cell_sel = 4'd0; out_mode = 1;
    @(negedge clk);
    tick();
    lit("rst_turn", bus.turn, 1);
    lit("rst_count", bus.move_count, 0);
    lit("rst_grid", dut_grid, 0);
    rst = 1'b0;

    // 1: first move at B2
    pulse_start();
    place_at(4);
    lit("t1_b2", bus.grid_B2, 1);
    lit("t1_ok", bus.move_ok, 1);
    lit("t1_cnt", bus.move_count, 1);
    tick();
    lit("t1_turn", bus.turn, 2);

    // 2: occupied cell
    place_at(4);
    lit("t2_err", bus.move_err, 1);
    lit("t2_b2", bus.grid_B2, 1);
    tick();
    lit("t2_turn", bus.turn, 2);
    lit("t2_cnt", bus.move_count, 1);

    // 3: invalid index, then place during check
    place_at(12);
    lit("t3_err_idx", bus.move_err, 1);
    tick();
    place_at(0);
    lit("t3_a1", bus.grid_A1, 2);
    place_at(5);
    lit("t3_err_chk", bus.move_err, 1);
    lit("t3_b3", bus.grid_B3, 0);
    tick();
    lit("t3_turn", bus.turn, 1);

    // 4: P1 completes row A
    pulse_start();
    place_at(0); tick();
    place_at(3); tick();
    place_at(1); tick();
    place_at(4); tick();
    place_at(2); tick();
    lit("t4_over", bus.game_over, 1);
    lit("t4_turn", bus.turn, 1);
    lit("t4_cnt", bus.move_count, 5);
    place_at(8);
    lit("t4_err", bus.move_err, 1);
    lit("t4_c3", bus.grid_C3, 0);
    tick();

    // 5: nine moves with outcome forced to in-progress
    out_mode = 0;
    pulse_start();
    for (int k = 0; k < 9; k++) begin
      place_at(k);
      tick();
    end
    lit("t5_over", bus.game_over, 1);
    lit("t5_cnt", bus.move_count, 9);
    lit("t5_grid", dut_grid, 18'h19999);
    pulse_start();
    lit("t5_clear", dut_grid, 0);
    lit("t5_cnt0", bus.move_count, 0);
    lit("t5_over0", bus.game_over, 0);
    out_mode = 1;

    // 6: start beats place; reset during check
    place_at(4); tick();
    bus.start = 1'b1; bus.place = 1'b1; bus.cell_sel = 4'd0;
    tick();
    bus.start = 1'b0; bus.place = 1'b0;
    lit("t6_clear", dut_grid, 0);
    lit("t6_err", bus.move_err, 0);
    lit("t6_ok", bus.move_ok, 0);
    lit("t6_turn", bus.turn, 1);
    place_at(2);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    lit("t6_rst_grid", dut_grid, 0);
    lit("t6_rst_cnt", bus.move_count, 0);
    lit("t6_rst_over", bus.game_over, 0);
    place_at(3);
    lit("t6_idle_err", bus.move_err, 1);
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
